cam_window_capture: RTL and testbench

//  Camera-side capture front end. Runs on pclk and counts lines (href rising edges) and pixels per line,

---
 rtl/cam_pkg.sv | 19 +
 rtl/cam_window_capture_if.sv | 27 ++
 rtl/cam_edge_sync.sv | 26 ++
 rtl/cam_window_capture.sv | 159 +++++++++++++++
 tb/tb_cam_window_capture.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera window capture (CAM_BYTE_PAIR_EN widens pixels)
package cam_pkg;

  typedef enum logic [1:0] {
    WAIT_VS,
    WAIT_LINE,
    IN_LINE,
    DONE
  } cam_state_t;

  localparam int CAM_STEP_W = 4;

`ifdef CAM_BYTE_PAIR_EN
  localparam int CAM_WR_MULT = 2;
`else
  localparam int CAM_WR_MULT = 1;
`endif

endpackage

// File: rtl/cam_window_capture_if.sv
// rtl/cam_window_capture_if.sv - camera input bus and frame-buffer write bus of the capture block
interface cam_window_capture_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
);
  import cam_pkg::*;

  localparam int WR_W = DATA_W * CAM_WR_MULT;

  logic              vsync;
  logic              href;
  logic [DATA_W-1:0] d_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WR_W-1:0]   wr_data;

  modport master (
    output vsync, href, d_in,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  vsync, href, d_in,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/cam_edge_sync.sv
// rtl/cam_edge_sync.sv - single register stage with rise/fall detect on the registered value
module cam_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/cam_window_capture.sv
// rtl/cam_window_capture.sv - windowed, line-decimated camera capture to linear frame-buffer writes
// CAM_BYTE_PAIR_EN: two bytes per pixel, wr_data is the byte pair with the first byte in the upper half
module cam_window_capture
  import cam_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PIX_W  = 10,
  parameter int LINE_W = 9,
  parameter int ADDR_W = 17
) (
  input  logic                  pclk,
  input  logic                  res_n,
  cam_window_capture_if.slave   cam,
  input  logic [PIX_W-1:0]      x_start,
  input  logic [PIX_W-1:0]      x_len,
  input  logic [LINE_W-1:0]     y_start,
  input  logic [LINE_W-1:0]     y_len,
  input  logic [CAM_STEP_W-1:0] y_step,
  output logic [LINE_W-1:0]     line_cnt,
  output logic                  frame_done,
  output logic                  overflow
);

  cam_state_t state, state_nxt;

  logic vs_q, vs_rise, vs_fall;
  logic hr_q, hr_rise, hr_fall;

  logic [PIX_W:0]          xs_s, xe_s, pix_q, p_cur;
  logic [LINE_W:0]         ys_s, ye_s, line_ext;
  logic [CAM_STEP_W-1:0]   step_s, step_cnt;
  logic [LINE_W-1:0]       line_idx;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       d_q;
  logic                    cap_q, addr_full;
  logic                    line_start, line_active, y_in_win, line_hit, cap_now;
  logic                    pix_due, x_hit, write_due, last_line;

  cam_edge_sync u_vs_sync (.clk(pclk), .rst_n(res_n), .d(cam.vsync), .q(vs_q), .rise(vs_rise), .fall(vs_fall));
  cam_edge_sync u_hr_sync (.clk(pclk), .rst_n(res_n), .d(cam.href),  .q(hr_q), .rise(hr_rise), .fall(hr_fall));

  // The first pixel of a line is presented in the same cycle the href rise is seen.
  assign line_start  = (state == WAIT_LINE) && hr_rise && !vs_q;
  assign line_active = line_start || ((state == IN_LINE) && hr_q);
  assign line_ext    = {1'b0, line_cnt};
  assign y_in_win    = (line_ext >= ys_s) && (line_ext < ye_s);
  assign line_hit    = y_in_win && (step_cnt == '0);
  assign cap_now     = line_start ? line_hit : cap_q;
  assign p_cur       = line_start ? '0 : pix_q;
  assign x_hit       = !p_cur[PIX_W] && (p_cur >= xs_s) && (p_cur < xe_s);
  assign write_due   = line_active && cap_now && pix_due && x_hit;
  assign last_line   = (ys_s != ye_s) && (({1'b0, line_idx} + (LINE_W+1)'(1)) == ye_s);

  assign cam.wr_en   = write_due && !addr_full;
  assign cam.wr_addr = addr_q;

`ifdef CAM_BYTE_PAIR_EN
  logic              ph_q, byte_ph;
  logic [DATA_W-1:0] hi_q;

  assign byte_ph     = line_start ? 1'b0 : ph_q;
  assign pix_due     = byte_ph;
  assign cam.wr_data = {hi_q, d_q};

  always_ff @(posedge pclk or negedge res_n) begin
    if (!res_n) begin
      ph_q <= 1'b0;
      hi_q <= '0;
    end else begin
      ph_q <= line_active ? ~byte_ph : 1'b0;
      if (line_active && !byte_ph) hi_q <= d_q;
    end
  end
`else
  assign pix_due     = 1'b1;
  assign cam.wr_data = d_q;
`endif

  always_ff @(posedge pclk or negedge res_n) begin
    if (!res_n) state <= WAIT_VS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    if (vs_rise) begin
      state_nxt = WAIT_VS;
    end else begin
      case (state)
        WAIT_VS:   if (vs_fall) state_nxt = WAIT_LINE;
        WAIT_LINE: if (line_start) state_nxt = IN_LINE;
        IN_LINE: begin
          if (hr_fall) begin
            if (last_line) begin
              state_nxt  = DONE;
              frame_done = 1'b1;
            end else begin
              state_nxt = WAIT_LINE;
            end
          end
        end
        DONE:      state_nxt = DONE;
        default:   state_nxt = WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge res_n) begin
    if (!res_n) begin
      d_q       <= '0;
      xs_s      <= '0;
      xe_s      <= '0;
      ys_s      <= '0;
      ye_s      <= '0;
      step_s    <= '0;
      step_cnt  <= '0;
      line_cnt  <= '0;
      line_idx  <= '0;
      pix_q     <= '0;
      cap_q     <= 1'b0;
      addr_q    <= '0;
      addr_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      d_q <= cam.d_in;
      if (vs_fall) begin
        xs_s      <= {1'b0, x_start};
        xe_s      <= {1'b0, x_start} + {1'b0, x_len};
        ys_s      <= {1'b0, y_start};
        ye_s      <= {1'b0, y_start} + {1'b0, y_len};
        step_s    <= (y_step == '0) ? CAM_STEP_W'(1) : y_step;
        step_cnt  <= '0;
        line_cnt  <= '0;
        addr_q    <= '0;
        addr_full <= 1'b0;
        overflow  <= 1'b0;
      end
      if (hr_rise && !vs_q && (state != WAIT_VS) && (line_cnt != '1))
        line_cnt <= line_cnt + LINE_W'(1);
      // step_cnt tracks the decimation phase of in-window lines, avoiding a divider
      if (line_start) begin
        cap_q    <= line_hit;
        line_idx <= line_cnt;
        if (y_in_win)
          step_cnt <= (step_cnt == step_s - CAM_STEP_W'(1)) ? '0 : step_cnt + CAM_STEP_W'(1);
      end
      if (line_active)
        pix_q <= (pix_due && !p_cur[PIX_W]) ? p_cur + (PIX_W+1)'(1) : p_cur;
      // The all-ones address is used once; any later write is dropped and flagged.
      if (write_due) begin
        if (addr_full)   overflow  <= 1'b1;
        else if (&addr_q) addr_full <= 1'b1;
        else             addr_q    <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cam_window_capture.sv
// tb/tb_cam_window_capture.sv - randomized frames checked against a pixel-level window model
module tb_cam_window_capture;
  import cam_pkg::*;

  localparam int DATA_W = 8;
  localparam int PIX_W  = 10;
  localparam int LINE_W = 9;
  localparam int ADDR_W = 17;
  localparam int ADDR_S = 3;
  localparam int BPP    = CAM_WR_MULT;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic pclk = 1'b0;
  logic res_n = 1'b0;
  always #5 pclk = ~pclk;

  logic [PIX_W-1:0]      x_start, x_len;
  logic [LINE_W-1:0]     y_start, y_len;
  logic [CAM_STEP_W-1:0] y_step;
  logic [LINE_W-1:0]     line_cnt, line_cnt3;
  logic                  frame_done, frame_done3, overflow, overflow3;

  cam_window_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  cam_window_capture_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_S)) bus3 ();

  assign bus3.vsync = bus.vsync;
  assign bus3.href  = bus.href;
  assign bus3.d_in  = bus.d_in;

  cam_window_capture #(.DATA_W(DATA_W), .PIX_W(PIX_W), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .pclk(pclk), .res_n(res_n), .cam(bus),
    .x_start(x_start), .x_len(x_len), .y_start(y_start), .y_len(y_len), .y_step(y_step),
    .line_cnt(line_cnt), .frame_done(frame_done), .overflow(overflow)
  );

  cam_window_capture #(.DATA_W(DATA_W), .PIX_W(PIX_W), .LINE_W(LINE_W), .ADDR_W(ADDR_S)) dut3 (
    .pclk(pclk), .res_n(res_n), .cam(bus3),
    .x_start(x_start), .x_len(x_len), .y_start(y_start), .y_len(y_len), .y_step(y_step),
    .line_cnt(line_cnt3), .frame_done(frame_done3), .overflow(overflow3)
  );

  int  n_checks = 0;
  int  n_pass   = 0;
  int  fd_cnt   = 0;
  int  wr_seen3 = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge pclk) begin
    if (bus.wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_extra", 32'(bus.wr_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.wr_addr), mon_e.addr);
        check("wr_data", 32'(bus.wr_data), mon_e.data);
      end
    end
    if (bus3.wr_en) begin
      check("wr_addr3", 32'(bus3.wr_addr), 32'(wr_seen3));
      wr_seen3++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic set_cfg(input int xs, input int xl, input int ys, input int yl, input int st);
    x_start = PIX_W'(xs);
    x_len   = PIX_W'(xl);
    y_start = LINE_W'(ys);
    y_len   = LINE_W'(yl);
    y_step  = CAM_STEP_W'(st);
  endtask

  // stop_line/stop_px: where vsync rises early (cut) or reset is pulsed (rst)
  task automatic run_frame(input int nlines, input int len, input int stop_line, input int stop_px,
                           input bit cut, input bit rst);
    int xs, xl, ys, yl, st, nexp, stop, exp_lines;
    bit live;
    logic [DATA_W-1:0] b, prev;
    bus.vsync = 1'b1;
    bus.href  = 1'b0;
    repeat (4) @(posedge pclk);
    #1;
    xs = int'(x_start); xl = int'(x_len); ys = int'(y_start); yl = int'(y_len);
    st = (y_step == 0) ? 1 : int'(y_step);
    bus.vsync = 1'b0;
    fd_cnt = 0; wr_seen3 = 0; nexp = 0; live = 1'b1; prev = '0;
    repeat (2) @(posedge pclk);
    #1;
    check("ovf_clear3", 32'(overflow3), 32'd0);
    set_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 15));
    for (int l = 0; l < nlines; l++) begin
      for (int k = 0; k < len; k++) begin
        b = DATA_W'($urandom);
        bus.href = 1'b1;
        bus.d_in = b;
        if (rst && l == stop_line && k == stop_px) begin
          res_n = 1'b0;
          live  = 1'b0;
          #1;
          check("rst_wr_en", 32'(bus.wr_en), 32'd0);
          check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
          check("rst_line_cnt", 32'(line_cnt), 32'd0);
          check("rst_overflow3", 32'(overflow3), 32'd0);
          exp_q.delete();
        end
        if (rst && l == stop_line && k == stop_px + 2) res_n = 1'b1;
        if (live && l >= ys && l < ys + yl && ((l - ys) % st) == 0) begin
          if (BPP == 1) begin
            if (k >= xs && k < xs + xl) begin
              exp_q.push_back('{addr: 32'(nexp), data: 32'(b)});
              nexp++;
            end
          end else if ((k % 2) == 1 && (k / 2) >= xs && (k / 2) < xs + xl) begin
            exp_q.push_back('{addr: 32'(nexp), data: 32'({prev, b})});
            nexp++;
          end
        end
        if (cut && l == stop_line && k == stop_px) begin
          bus.vsync = 1'b1;
          live      = 1'b0;
        end
        prev = b;
        @(posedge pclk);
        #1;
      end
      res_n    = 1'b1;
      bus.href = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
    end
    stop      = (cut || rst) ? stop_line : nlines;
    exp_lines = rst ? 0 : (cut ? stop_line + 1 : nlines);
    check("frame_done_cnt", 32'(fd_cnt), (yl != 0 && ys + yl <= stop) ? 32'd1 : 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("line_cnt", 32'(line_cnt), 32'(exp_lines));
    check("overflow", 32'(overflow), 32'd0);
    if (!rst) begin
      check("wr_cnt3", 32'(wr_seen3), 32'((nexp > 8) ? 8 : nexp));
      check("overflow3", 32'(overflow3), 32'(nexp > 8));
    end
  endtask

  initial begin
    int nl, ln, mode;
    bus.vsync = 1'b0;
    bus.href  = 1'b0;
    bus.d_in  = '0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge pclk);
    #1;
    check("reset_wr_en", 32'(bus.wr_en), 32'd0);
    check("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("reset_wr_data", 32'(bus.wr_data), 32'd0);
    check("reset_line_cnt", 32'(line_cnt), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    res_n = 1'b1;

    set_cfg(4, 4, 2, 3, 1);
    run_frame(8, 16 * BPP, 0, 0, 1'b0, 1'b0);
    set_cfg(4, 4, 2, 3, 2);
    run_frame(8, 16 * BPP, 0, 0, 1'b0, 1'b0);
    set_cfg(2, 8, 1, 5, 1);
    run_frame(8, 16 * BPP, 3, 5, 1'b0, 1'b1);
    set_cfg(2, 8, 1, 5, 1);
    run_frame(8, 16 * BPP, 2, 6, 1'b1, 1'b0);
    set_cfg(0, 2, 0, 1, 0);
    run_frame(3, 5, 0, 0, 1'b0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      nl   = $urandom_range(3, 9);
      ln   = $urandom_range(4, 20);
      mode = $urandom_range(0, 5);
      set_cfg($urandom_range(0, ln), $urandom_range(0, 8), $urandom_range(0, nl),
              $urandom_range(0, 5), $urandom_range(0, 4));
      run_frame(nl, ln, $urandom_range(0, nl - 1), $urandom_range(0, ln - 1),
                mode == 0, mode == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
